simd_alu_issue: RTL

Issue and writeback stage that sits directly upstream of the packed-lane SIMD ALU (LANES lanes of LANE_W bits, 3-bit mode). It holds a small 64-bit register file and accepts register-addressed instructions over a valid/ready handshake. It drives registered operands and mode into the ALU, captures the ALU result and writes it back to the register file. A host port loads and inspects registers.

---
 rtl/simd_alu_issue.sv | 135 +++++++++++++
 1 files changed

// File: rtl/simd_alu_issue.sv
// Issue/writeback stage feeding a packed-lane SIMD ALU from an 8x64 register file.
// Optional: define RETIRE_CNT_EN to add a 16-bit count of completed writebacks.
module simd_alu_issue #(
    parameter int LANES  = 8,
    parameter int LANE_W = 8,
    parameter int AW     = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      instr_valid,
    output logic                      instr_ready,
    input  logic [2:0]                instr_mode,
    input  logic [AW-1:0]             instr_rd,
    input  logic [AW-1:0]             instr_ra,
    input  logic [AW-1:0]             instr_rb,
    output logic [LANES*LANE_W-1:0]   alu_a,
    output logic [LANES*LANE_W-1:0]   alu_b,
    output logic [2:0]                alu_mode,
    input  logic [LANES*LANE_W-1:0]   alu_result,
    output logic                      wb_valid,
    output logic [AW-1:0]             wb_addr,
    output logic [LANES*LANE_W-1:0]   wb_data,
    input  logic                      host_wr_en,
    input  logic [AW-1:0]             host_wr_addr,
    input  logic [LANES*LANE_W-1:0]   host_wr_data,
    input  logic [AW-1:0]             host_rd_addr,
    output logic [LANES*LANE_W-1:0]   host_rd_data
`ifdef RETIRE_CNT_EN
    ,
    output logic [15:0]               retire_count
`endif
);
    localparam int W    = LANES * LANE_W;
    localparam int NREG = 2 ** AW;

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    rf_q [NREG];
    logic [W-1:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0]      alu_mode_q, alu_mode_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic            wb_valid_q, wb_valid_d;
    logic [AW-1:0]   wb_addr_q, wb_addr_d;
    logic [W-1:0]    wb_data_q, wb_data_d;
    logic            accept;
    logic            wb_commit;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (instr_valid) state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state_q == IDLE) && !reset;
        accept      = instr_valid && instr_ready;
        wb_commit   = (state_q == WB);
    end

    always_comb begin
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_mode_d = alu_mode_q;
        rd_d       = rd_q;
        wb_valid_d = wb_valid_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        if (accept) begin
            alu_a_d    = rf_q[instr_ra];
            alu_b_d    = rf_q[instr_rb];
            alu_mode_d = instr_mode;
            rd_d       = instr_rd;
        end
        if (state_q == EXEC) begin
            wb_data_d  = alu_result;
            wb_addr_d  = rd_q;
            wb_valid_d = 1'b1;
        end
        if (wb_commit) wb_valid_d = 1'b0;
    end

    // Writeback is assigned after the host write so it wins an address collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_mode_q <= 3'b000;
            rd_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            if (host_wr_en) rf_q[host_wr_addr] <= host_wr_data;
            if (wb_commit)  rf_q[wb_addr_q]    <= wb_data_q;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_mode_q <= alu_mode_d;
            rd_q       <= rd_d;
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_mode     = alu_mode_q;
    assign wb_valid     = wb_valid_q;
    assign wb_addr      = wb_addr_q;
    assign wb_data      = wb_data_q;
    assign host_rd_data = rf_q[host_rd_addr];

`ifdef RETIRE_CNT_EN
    logic [15:0] retire_q;

    always_ff @(posedge clk) begin
        if (reset)          retire_q <= '0;
        else if (wb_commit) retire_q <= retire_q + 16'd1;
    end

    assign retire_count = retire_q;
`endif

endmodule
